// File: rtl/reflector_pkg.sv
// Shared types and helpers for the configurable reflector: FSM state encoding,
// the wiring-table type and the conversion of a wiring string into a table.
package reflector_pkg;

  localparam int MAX_N = 64;
  localparam int MAX_W = 6;

  localparam logic [7:0] ASCII_A = 8'h41;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  // Widest table any legal alphabet can need; users slice out N entries of W bits.
  typedef logic [MAX_N-1:0][MAX_W-1:0] map_t;

  // Character k of the string (leftmost first) is the image of letter k, as 'A'+index.
  // A string literal packs its first character into the most significant byte.
  function automatic map_t map_from_string(input logic [8*MAX_N-1:0] str, input int n);
    map_t m;
    m = '0;
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        m[k] = MAX_W'(str[8*(n-1-k) +: 8] - ASCII_A);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/reflector_if.sv
// Letter path and configuration port bundle of the reflector.
// onehot_err exists only when REFLECTOR_ONEHOT_CHECK_EN is defined.
interface reflector_if #(
  parameter int N = 26,
  parameter int W = $clog2(N)
) ();

  logic         in_valid;
  logic [N-1:0] in;
  logic         out_valid;
  logic [N-1:0] out;
  logic         cfg_start;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_a;
  logic [W-1:0] cfg_b;
  logic         cfg_done;
  logic         cfg_err;
  logic         busy;
`ifdef REFLECTOR_ONEHOT_CHECK_EN
  logic         onehot_err;

  modport master (
    output in_valid, in, cfg_start, cfg_valid, cfg_a, cfg_b,
    input  out_valid, out, cfg_ready, cfg_done, cfg_err, busy, onehot_err
  );

  modport slave (
    input  in_valid, in, cfg_start, cfg_valid, cfg_a, cfg_b,
    output out_valid, out, cfg_ready, cfg_done, cfg_err, busy, onehot_err
  );
`else
  modport master (
    output in_valid, in, cfg_start, cfg_valid, cfg_a, cfg_b,
    input  out_valid, out, cfg_ready, cfg_done, cfg_err, busy
  );

  modport slave (
    input  in_valid, in, cfg_start, cfg_valid, cfg_a, cfg_b,
    output out_valid, out, cfg_ready, cfg_done, cfg_err, busy
  );
`endif

endinterface

// File: rtl/reflector_perm.sv
// Combinational bit permutation: input bit i lands on output bit map[i].
// Multi-hot inputs fan out bitwise; a zero input gives zero.
module reflector_perm #(
  parameter int N = 26,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0]        vec,
  input  logic [N-1:0][W-1:0] map,
  output logic [N-1:0]        res
);

  always_comb begin
    // NOTE: res gets a full default before the loop so no bit is left
    // unassigned on any path; otherwise synthesis would infer latches.
    res = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        res[map[i]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reflector_cfg.sv
// Field-rewirable reflector: 1-cycle one-hot permutation through an active table,
// with a shadow table loaded as letter pairs, validated, then committed atomically.
// Optional REFLECTOR_ONEHOT_CHECK_EN flags and zeroes non-one-hot letters.
module reflector_cfg
  import reflector_pkg::*;
#(
  parameter int             N           = 26,
  parameter int             W           = $clog2(N),
  parameter logic [8*N-1:0] DEFAULT_MAP = "YRUHQSLDPXNGOKMIEBFZCWVJAT"
) (
  input logic         clk,
  input logic         rst_n,
  reflector_if.slave  bus
);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] LOAD   = ST_LOAD;
  localparam logic [1:0] CHECK  = ST_CHECK;
  localparam logic [1:0] COMMIT = ST_COMMIT;

  localparam map_t DEF_FULL = map_from_string((8*MAX_N)'(DEFAULT_MAP), N);

  logic [1:0]          state;
  logic [N-1:0][W-1:0] active;
  logic [N-1:0][W-1:0] shadow;
  logic [N-1:0]        used;
  logic [W-1:0]        pair_cnt;
  logic [W-1:0]        idx;
  logic                cfg_err_q;

  logic [N-1:0]        perm_out;
  logic [N-1:0]        out_q;
  logic                out_valid_q;

  // ---------------------------------------------------------------- data path
  reflector_perm #(.N(N), .W(W)) u_perm (
    .vec (bus.in),
    .map (active),
    .res (perm_out)
  );

`ifdef REFLECTOR_ONEHOT_CHECK_EN
  logic in_onehot;
  logic onehot_err_q;

  assign in_onehot = (bus.in != '0) && ((bus.in & (bus.in - N'(1))) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      onehot_err_q <= 1'b0;
    end else begin
      out_valid_q  <= bus.in_valid;
      onehot_err_q <= bus.in_valid && !in_onehot;
      if (bus.in_valid) begin
        out_q <= in_onehot ? perm_out : '0;
      end
    end
  end

  assign bus.onehot_err = onehot_err_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere in clocked blocks, so every
      // register samples pre-edge values regardless of statement order.
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_q <= perm_out;
      end
    end
  end
`endif

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

  // ------------------------------------------------------ pair validation
  logic accept;
  logic clear_load;
  logic a_oob;
  logic b_oob;
  logic pair_bad;

  assign accept     = bus.cfg_valid && (state == LOAD);
  assign clear_load = bus.cfg_start && ((state == IDLE) || (state == LOAD));

  always_comb begin
    a_oob    = {1'b0, bus.cfg_a} >= (W+1)'(N);
    b_oob    = {1'b0, bus.cfg_b} >= (W+1)'(N);
    // used[] is only consulted for in-range letters.
    pair_bad = a_oob || b_oob || (bus.cfg_a == bus.cfg_b)
            || (!a_oob && used[bus.cfg_a])
            || (!b_oob && used[bus.cfg_b]);
  end

  // ----------------------------------------------------- involution check
  logic [W-1:0] partner;
  logic         partner_oob;
  logic         chk_bad;

  always_comb begin
    partner     = shadow[idx];
    partner_oob = {1'b0, partner} >= (W+1)'(N);
    chk_bad     = partner_oob || (partner == idx) || (shadow[partner] != idx);
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      used      <= '0;
      pair_cnt  <= '0;
      idx       <= '0;
      cfg_err_q <= 1'b0;
      // NOTE: both tables are flops with a reset value, not a RAM, so an
      // asynchronous reset mid-load restores the default wiring in one step.
      for (int i = 0; i < N; i++) begin
        active[i] <= DEF_FULL[i][W-1:0];
        shadow[i] <= DEF_FULL[i][W-1:0];
      end
    end else if (clear_load) begin
      state     <= LOAD;
      used      <= '0;
      pair_cnt  <= '0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        shadow[i] <= W'(i);
      end
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (pair_bad) begin
              cfg_err_q <= 1'b1;
              state     <= IDLE;
            end else begin
              shadow[bus.cfg_a] <= bus.cfg_b;
              shadow[bus.cfg_b] <= bus.cfg_a;
              used[bus.cfg_a]   <= 1'b1;
              used[bus.cfg_b]   <= 1'b1;
              pair_cnt          <= pair_cnt + W'(1);
              if (pair_cnt == W'(N/2 - 1)) begin
                idx   <= '0;
                state <= CHECK;
              end
            end
          end
        end
        CHECK: begin
          if (chk_bad) begin
            cfg_err_q <= 1'b1;
            state     <= IDLE;
          end else if (idx == W'(N-1)) begin
            state <= COMMIT;
          end else begin
            idx <= idx + W'(1);
          end
        end
        COMMIT: begin
          // Letters sampled on this edge still see the old table.
          active <= shadow;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready = (state == LOAD);
  assign bus.cfg_done  = (state == COMMIT);
  assign bus.busy      = (state != IDLE);
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_reflector_cfg.sv
// Directed bench for reflector_cfg: a letter-level model of the active wiring plus
// commit timing, compared every cycle, with hand-computed literal expectations.
module tb_reflector_cfg;

  localparam int N = 26;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst_n;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int commit_edge = -1;
  int acc = 0;
  int done_at = -1;

  int def_map[N];
  int model_map[N];
  int pending_map[N];

  logic [N-1:0] exp_out;
  logic         exp_valid;
  logic         exp_done;
  logic         exp_oh;

  reflector_if #(.N(N), .W(W)) bus ();

  reflector_cfg #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    string s;
    s = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    for (int k = 0; k < N; k++) def_map[k] = int'(s[k]) - 65;
  end

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // Reflection of a letter vector through the model's current wiring.
  function automatic logic [N-1:0] reflect(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
`ifdef REFLECTOR_ONEHOT_CHECK_EN
    if ($countones(v) != 1) return '0;
`endif
    for (int i = 0; i < N; i++) if (v[i]) r[model_map[i]] = 1'b1;
    return r;
  endfunction

  // Model: one sample per edge; the wiring swaps after the commit edge's sample.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_map = def_map;
      exp_valid = 1'b0;
      exp_out   = '0;
      exp_done  = 1'b0;
      exp_oh    = 1'b0;
    end else begin
      cyc++;
      exp_done  = (cyc == commit_edge - 1);
      exp_valid = bus.in_valid;
      exp_oh    = 1'b0;
      if (bus.in_valid) begin
        exp_out = reflect(bus.in);
`ifdef REFLECTOR_ONEHOT_CHECK_EN
        exp_oh  = ($countones(bus.in) != 1);
`endif
      end
      if (cyc == commit_edge) model_map = pending_map;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    if (rst_n === 1'b1) begin
      check("model_out_valid", bus.out_valid, exp_valid);
      check("model_out", bus.out, exp_out);
      check("model_cfg_done", bus.cfg_done, exp_done);
`ifdef REFLECTOR_ONEHOT_CHECK_EN
      check("model_onehot_err", bus.onehot_err, exp_oh);
`endif
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
  endtask

  task automatic start_load();
    bus.cfg_start = 1'b1;
    step();
    bus.cfg_start = 1'b0;
    check("load_ready", bus.cfg_ready, 1'b1);
    check("load_busy", bus.busy, 1'b1);
    check("load_err_cleared", bus.cfg_err, 1'b0);
  endtask

  task automatic send_pair(input int a, input int b);
    bus.cfg_valid = 1'b1;
    bus.cfg_a     = W'(a);
    bus.cfg_b     = W'(b);
    step();
    acc           = cyc;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic expect_error(input string name);
    check({name, "_err"}, bus.cfg_err, 1'b1);
    check({name, "_busy"}, bus.busy, 1'b0);
    check({name, "_ready"}, bus.cfg_ready, 1'b0);
    step();
    check({name, "_A_still_Y"}, bus.out, oh(24));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in        = '0;
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_a     = '0;
    bus.cfg_b     = '0;
    repeat (2) @(negedge clk);
    check("rst_out", bus.out, '0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ready", bus.cfg_ready, 1'b0);
    check("rst_err", bus.cfg_err, 1'b0);
    check("rst_done", bus.cfg_done, 1'b0);
    rst_n = 1'b1;

    // Default wiring: A -> Y
    bus.in_valid = 1'b1;
    bus.in       = oh(0);
    step();
    check("A_to_Y", bus.out, oh(24));
    check("A_valid", bus.out_valid, 1'b1);

    // Full load of adjacent pairs while A streams every cycle.
    start_load();
    for (int k = 0; k < N/2; k++) send_pair(2*k, 2*k + 1);
    for (int i = 0; i < N; i++) pending_map[i] = i ^ 1;
    commit_edge = acc + N + 1;
    done_at = -1;
    for (int i = 0; i < N + 8 && done_at < 0; i++) begin
      step();
      if (bus.cfg_done === 1'b1) done_at = cyc;
    end
    check("done_latency", 64'(done_at - acc + 1), 64'd27);
    step();
    check("commit_sample_old", bus.out, oh(24));
    step();
    check("after_commit_new", bus.out, oh(1));
    check("no_valid_gap", bus.out_valid, 1'b1);
    bus.in = oh(4);
    step();
    check("E_to_F", bus.out, oh(5));
    bus.in = oh(25);
    step();
    check("Z_to_Y", bus.out, oh(24));

    // Reset in the middle of a load restores the default wiring.
    bus.in = oh(0);
    start_load();
    for (int k = 0; k < 5; k++) send_pair(2*k, 2*k + 1);
    rst_n       = 1'b0;
    commit_edge = -1;
    #1;
    check("midrst_out", bus.out, '0);
    check("midrst_valid", bus.out_valid, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_ready", bus.cfg_ready, 1'b0);
    check("midrst_err", bus.cfg_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("midrst_A_to_Y", bus.out, oh(24));

    // Rejected pairs leave the active wiring alone.
    start_load();
    send_pair(3, 3);
    expect_error("self_pair");
    start_load();
    send_pair(0, 1);
    send_pair(0, 2);
    expect_error("dup_letter");
    start_load();
    send_pair(26, 0);
    expect_error("oob_letter");

    // Non-one-hot letters.
    bus.in = 26'b11;
    step();
`ifdef REFLECTOR_ONEHOT_CHECK_EN
    check("multihot_out", bus.out, '0);
    check("multihot_valid", bus.out_valid, 1'b1);
    check("multihot_flag", bus.onehot_err, 1'b1);
`else
    check("multihot_out", bus.out, oh(24) | oh(17));
`endif
    bus.in = oh(0);
    step();
    check("A_after_multihot", bus.out, oh(24));
`ifdef REFLECTOR_ONEHOT_CHECK_EN
    check("flag_pulse_ends", bus.onehot_err, 1'b0);
`endif
    bus.in = '0;
    step();
    check("zero_in", bus.out, '0);

    // Idle input holds the last reflected letter.
    bus.in = oh(1);
    step();
    check("B_to_R", bus.out, oh(17));
    bus.in_valid = 1'b0;
    bus.in       = oh(4);
    step();
    check("idle_valid_low", bus.out_valid, 1'b0);
    check("idle_out_holds", bus.out, oh(17));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
